// File: rtl/des_key_schedule.sv
// des_key_schedule: sequential DES key schedule emitting one pre-PC-2 round key (C||D) per handshake
//    clk, rst        : clock, asynchronous active-high reset
//    start, decrypt  : load request (honoured only in IDLE) and round-order select (1 = decrypt)
//    key             : 64-bit DES key, bit 1 = MSB, parity bits 8,16,...,64 ignored
//    busy, out_valid : schedule in progress / pc2_key and round_num hold a valid round key
//    out_ready       : consumer accepts the current round key
//    pc2_key         : C (bits 1-28) || D (bits 29-56), feeds the PC-2 stage
//    round_num       : round index 0..15 in issue order
//    done            : one-cycle pulse after the 16th key is accepted
module des_key_schedule (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        decrypt,
   input  logic [1:64] key,
   output logic        busy,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [1:56] pc2_key,
   output logic [3:0]  round_num,
   output logic        done
);
   typedef enum logic {IDLE, RUN} state_t;
   localparam int PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
   state_t      state, state_n;
   logic        dec, dec_n, done_n, two;
   logic [1:28] c, d, c_n, d_n, pc1_c, pc1_d;
   logic [3:0]  round_n;
   logic [4:0]  idx;

   function automatic logic [1:28] rotl(input logic [1:28] x, input logic by2);
      return by2 ? {x[3:28], x[1:2]} : {x[2:28], x[1]};
   endfunction

   function automatic logic [1:28] rotr(input logic [1:28] x, input logic by2);
      return by2 ? {x[27:28], x[1:26]} : {x[28], x[1:27]};
   endfunction

   always_comb begin
      for (int i = 0; i < 28; i++) begin
         pc1_c[i+1] = key[PC1[i]];
         pc1_d[i+1] = key[PC1[i+28]];
      end
   end

   // Schedule index of the rotation that produces the next round:
   // encrypt walks s2..s16, decrypt walks s16 down to s2.
   assign idx = dec ? 5'd16 - {1'b0, round_num} : {1'b0, round_num} + 5'd2;
   assign two = !(idx == 5'd1 || idx == 5'd2 || idx == 5'd9 || idx == 5'd16);

   assign busy      = (state == RUN);
   assign out_valid = (state == RUN);
   assign pc2_key   = {c, d};

   always_comb begin
      state_n = state;
      dec_n   = dec;
      c_n     = c;
      d_n     = d;
      round_n = round_num;
      done_n  = 1'b0;
      if (state == IDLE) begin
         if (start) begin
            state_n = RUN;
            dec_n   = decrypt;
            round_n = '0;
            // Encrypt presents C1||D1 first (pre-rotated by s1 = 1); decrypt presents C0||D0.
            c_n     = decrypt ? pc1_c : rotl(pc1_c, 1'b0);
            d_n     = decrypt ? pc1_d : rotl(pc1_d, 1'b0);
         end
      end else if (out_ready) begin
         if (round_num == 4'd15) begin
            state_n = IDLE;
            done_n  = 1'b1;
         end else begin
            round_n = round_num + 4'd1;
            c_n     = dec ? rotr(c, two) : rotl(c, two);
            d_n     = dec ? rotr(d, two) : rotl(d, two);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         dec       <= 1'b0;
         c         <= '0;
         d         <= '0;
         round_num <= '0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         dec       <= dec_n;
         c         <= c_n;
         d         <= d_n;
         round_num <= round_n;
         done      <= done_n;
      end
   end
endmodule

// File: tb/tb_des_key_schedule.sv
// tb_des_key_schedule: randomized self-checking bench for des_key_schedule against a cumulative-shift model
module tb_des_key_schedule;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0, decrypt = 1'b0, out_ready = 1'b0;
   logic [1:64] key = '0;
   logic        busy, out_valid, done;
   logic [1:56] pc2_key;
   logic [3:0]  round_num;
   int          total = 0, bad = 0, mr = 0, dones = 0, hs = 0;
   bit          pend = 1'b0;
   logic [1:56] mk [16];

   localparam int PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
   localparam int PC2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
   localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
   localparam logic [1:64] KEY_A = 64'h133457799BBCDFF1;

   des_key_schedule dut (
      .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .key(key),
      .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
      .pc2_key(pc2_key), .round_num(round_num), .done(done));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [1:28] rotl(input logic [1:28] x, input int n);
      return (x << n) | (x >> (28 - n));
   endfunction

   // Round i (1-based) key is PC-1 halves rotated left by the running sum of shifts;
   // decrypt issues the same list backwards.
   function automatic void model(input logic [1:64] k, input bit dec);
      logic [1:28] c0, d0;
      int sh = 0;
      for (int i = 0; i < 28; i++) begin
         c0[i+1] = k[PC1[i]];
         d0[i+1] = k[PC1[i+28]];
      end
      for (int i = 0; i < 16; i++) begin
         sh += SH[i];
         mk[dec ? 15 - i : i] = {rotl(c0, sh % 28), rotl(d0, sh % 28)};
      end
   endfunction

   function automatic logic [1:48] pc2(input logic [1:56] x);
      logic [1:48] r;
      for (int i = 0; i < 48; i++) r[i+1] = x[PC2[i]];
      return r;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         check("reset_outputs", {out_valid, busy, done, round_num, pc2_key}, 64'd0);
         mr   = 0;
         pend = 1'b0;
      end else begin
         check("done", done, pend);
         if (done) dones++;
         pend = 1'b0;
         check("busy", busy, out_valid);
         if (out_valid) begin
            check("round_num", round_num, mr);
            check("pc2_key", pc2_key, mk[mr]);
            if (out_ready) begin
               hs++;
               pend = (mr == 15);
               mr   = (mr + 1) % 16;
            end
         end
      end
   end

   task automatic run(input logic [1:64] k, input bit dec, input bit rnd, input int glitch, output int lat);
      model(k, dec);
      key     = k;
      decrypt = dec;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start   = 1'b0;
      key     = {$urandom, $urandom};
      decrypt = ~dec;
      check("start_latency", out_valid, 1'b1);
      lat = 0;
      while (!done && lat < 400) begin
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         start     = out_valid && int'(round_num) == glitch;
         if (start) key = {$urandom, $urandom};
         @(posedge clk);
         #1;
         lat++;
      end
      start = 1'b0;
      if (lat >= 400) check("timeout_done", done, 1'b1);
   endtask

   initial begin
      int lat, d0, h0;
      model(KEY_A, 1'b0);
      check("model_round0", mk[0], 56'hE19955FAACCF1E);
      check("model_round15", mk[15], 56'hF0CCAAF556678F);
      check("model_k1", pc2(mk[0]), 48'h1B02EFFC7072);
      check("model_k16", pc2(mk[15]), 48'hCB3D8B0E17F5);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      d0 = dones;
      run(KEY_A, 1'b0, 1'b0, -1, lat);
      check("enc_latency", lat, 16);
      repeat (3) @(posedge clk);
      #1;
      check("enc_one_done", dones - d0, 1);

      model(KEY_A, 1'b1);
      key = KEY_A; decrypt = 1'b1; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("dec_round0_literal", pc2_key, 56'hF0CCAAF556678F);
      repeat (15) @(posedge clk);
      #1;
      check("dec_round15_literal", pc2_key, 56'hE19955FAACCF1E);
      @(posedge clk);
      #1;
      check("dec_done", done, 1'b1);
      repeat (2) @(posedge clk);
      #1;

      d0 = dones; h0 = hs;
      run({$urandom, $urandom}, 1'b0, 1'b1, -1, lat);
      repeat (3) @(posedge clk);
      #1;
      check("bp_handshakes", hs - h0, 16);
      check("bp_one_done", dones - d0, 1);

      d0 = dones;
      run(KEY_A, 1'b1, 1'b0, 5, lat);
      check("glitch_latency", lat, 16);
      repeat (3) @(posedge clk);
      #1;
      check("glitch_one_done", dones - d0, 1);

      model({$urandom, $urandom}, 1'b0);
      key = {$urandom, $urandom};
      model(key, 1'b0);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      out_ready = 1'b1;
      while (round_num != 4'd7) @(posedge clk);
      #3;
      d0 = dones;
      rst = 1'b1;
      #1;
      check("async_reset", {out_valid, busy, done, round_num, pc2_key}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_no_done", dones - d0, 0);
      model(KEY_A, 1'b0);
      key = KEY_A; decrypt = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("post_reset_round0", pc2_key, 56'hE19955FAACCF1E);
      while (!done) @(posedge clk);
      #1;

      d0 = dones;
      run(KEY_A ^ 64'h0101010101010101, 1'b0, 1'b0, -1, lat);
      run({$urandom, $urandom}, 1'b1, 1'b0, -1, lat);
      check("b2b_latency", lat, 16);
      repeat (3) @(posedge clk);
      #1;
      check("b2b_dones", dones - d0, 2);
      model(KEY_A ^ 64'h0101010101010101, 1'b0);
      check("parity_model", mk[0], 56'hE19955FAACCF1E);

      for (int t = 0; t < 6; t++) begin
         run({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1, $urandom_range(0, 15), lat);
         repeat (2) @(posedge clk);
         #1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
